hd_uart_tx_ctrl: RTL

UART transmitter for a single-wire half-duplex link. It buffers bytes in a FIFO, serialises them 8N1, and drives a direction-enable output so the line driver is on only while a burst is being sent. Guard periods are inserted before and after each burst. It is the transmit end of the ARDUINO_IO half-duplex channel and replaces software toggling of the direction flag; the existing uart core keeps the receive side.

---
 rtl/hd_uart_tx_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hd_uart_tx_ctrl.sv
// Half-duplex 8N1 UART transmitter with byte FIFO and guarded direction enable.
// Define ECHO_CHECK_EN to compare line read-back against driven bits (collision_o).
module hd_uart_tx_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int GUARD_BITS = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       wr_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       overflow_o,
    output logic       txd_o,
    output logic       tx_en_o,
    output logic       busy_o,
    input  logic       rxd_i,
    output logic       collision_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam int GW  = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

    typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, TRAIL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          bit_end, push, pop, txd_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_d;

    assign bit_end = (baud_q == BIT_LAST);
    assign push    = wr_i && !full_o;

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        guard_d = guard_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty_o) begin
                    guard_d = '0;
                    if (GUARD_BITS == 0) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = LEAD;
                    end
                end
            end
            LEAD: if (bit_end) begin
                if (guard_q == GUARD_LAST) begin
                    state_d = START;
                    pop     = 1'b1;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                if (idx_q == 3'd7) state_d = STOP;
                else               idx_d   = idx_q + 1'b1;
            end
            STOP: if (bit_end) begin
                // Refilled FIFO keeps the burst going without a guard gap
                if (!empty_o) begin
                    state_d = START;
                    pop     = 1'b1;
                end else if (GUARD_BITS == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = TRAIL;
                    guard_d = '0;
                end
            end
            TRAIL: if (bit_end) begin
                if (guard_q == GUARD_LAST) state_d = IDLE;
                else                       guard_d = guard_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) baud_d = '0;
        if (pop) shreg_d = mem[rd_ptr];

        // Line value is registered from the next-state view so txd_o has no decode glitches
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[idx_d];
            default: txd_d = 1'b1;
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            guard_q    <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            txd_o      <= 1'b1;
            tx_en_o    <= 1'b0;
            busy_o     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            guard_q    <= guard_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            txd_o      <= txd_d;
            tx_en_o    <= (state_d != IDLE);
            busy_o     <= (state_d != IDLE);
            count_q    <= count_d;
            full_o     <= (count_d == (AW+1)'(FIFO_DEPTH));
            empty_o    <= (count_d == '0);
            overflow_o <= wr_i && full_o;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

`ifdef ECHO_CHECK_EN
    logic rx_s1, rx_s2, sample;

    // Mid-bit sample leaves room for the two synchroniser stages (DIV >= 4)
    assign sample = (state_q == START || state_q == DATA || state_q == STOP) &&
                    (baud_q == CW'(DIV / 2));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            collision_o <= 1'b0;
        end else begin
            rx_s1 <= rxd_i;
            rx_s2 <= rx_s1;
            if (sample && (rx_s2 != txd_o)) collision_o <= 1'b1;
        end
    end
`else
    logic unused_rxd;
    assign unused_rxd  = rxd_i;
    assign collision_o = 1'b0;
`endif

endmodule
